// File: rtl/vga_if.sv
// Video timing bundle between the raster generator and its consumers.
// Carries the run enable toward the generator and the timing strobes and coordinates back out.
`timescale 1ns/1ps
interface vga_if #(
  parameter int CNT_W = 10
);
  logic             en;
  logic             pix_ce;
  logic             hsync;
  logic             vsync;
  logic             de;
  logic [CNT_W-1:0] x;
  logic [CNT_W-1:0] y;
  logic             line_start;
  logic             frame_start;

  modport master (
    input  en,
    output pix_ce, hsync, vsync, de, x, y, line_start, frame_start
  );

  modport slave (
    output en,
    input  pix_ce, hsync, vsync, de, x, y, line_start, frame_start
  );
endinterface

// File: rtl/vga_timing_gen.sv
// Raster timing generator: divides clk into a pixel rate and emits registered sync,
// data-enable, coordinates and line/frame start strobes for each pixel.
`timescale 1ns/1ps
module vga_timing_gen #(
  parameter int CLK_DIV  = 2,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int CNT_W    = 10
) (
  input  logic   clk,
  input  logic   rst,
  vga_if.master  vif
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;
  localparam int DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);

  logic [DIV_W-1:0] div_cnt;
  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  logic             tick;
  logic             h_wrap;
  logic             hs_act;
  logic             vs_act;
  logic             de_nxt;
  int               h_i;
  int               v_i;

  // Decode of the pixel the counters point at; it is loaded into the output regs on tick.
  always_comb begin
    h_i    = int'(h_cnt);
    v_i    = int'(v_cnt);
    tick   = vif.en && (div_cnt == DIV_LAST);
    h_wrap = (h_cnt == H_LAST);
    hs_act = (h_i >= HS_START) && (h_i < HS_END);
    vs_act = (v_i >= VS_START) && (v_i < VS_END);
    de_nxt = (h_i < H_ACTIVE) && (v_i < V_ACTIVE);
  end

  // NOTE: every register here uses <= so all of them sample the pre-edge counter values;
  // a blocking assignment would let the output decode see the already-advanced counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt         <= '0;
      h_cnt           <= '0;
      v_cnt           <= '0;
      vif.pix_ce      <= 1'b0;
      vif.line_start  <= 1'b0;
      vif.frame_start <= 1'b0;
      vif.hsync       <= ~HS_POL;
      vif.vsync       <= ~VS_POL;
      vif.de          <= 1'b0;
      vif.x           <= '0;
      vif.y           <= '0;
    end else begin
      // Strobes are rewritten every clock so they fall on their own, including while en=0.
      vif.pix_ce      <= tick;
      vif.line_start  <= tick && (h_cnt == '0);
      vif.frame_start <= tick && (h_cnt == '0) && (v_cnt == '0);

      if (vif.en) begin
        div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
      end

      if (tick) begin
        vif.hsync <= hs_act ? HS_POL : ~HS_POL;
        vif.vsync <= vs_act ? VS_POL : ~VS_POL;
        vif.de    <= de_nxt;
        vif.x     <= de_nxt ? h_cnt : '0;
        vif.y     <= de_nxt ? v_cnt : '0;

        if (h_wrap) begin
          h_cnt <= '0;
          v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
        end else begin
          h_cnt <= h_cnt + 1'b1;
        end
      end
    end
  end

endmodule
